// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and transaction owner.
// Round-robin arbitration is selected by defining MEM_ARB_RR_EN (see mem_arb_pick).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_D) ? OWNER_I : OWNER_D;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch (I) and data (D) requesters.
// MEM_ARB_RR_EN defined: a tie goes to the port that did not own the last transaction.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_elig,
    input  logic   d_elig,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority keeps last_owner tracked upstream but unused here.
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;
`endif

    always_comb begin
        grant_valid = i_elig | d_elig;
        grant_owner = OWNER_D;
        if (i_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
            grant_owner = other_owner(last_owner);
`else
            grant_owner = OWNER_D;
`endif
        end else if (i_elig) begin
            grant_owner = OWNER_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I, read-only) and data (D) ports,
// one outstanding transaction at a time. Define MEM_ARB_RR_EN for round-robin ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                arb_busy
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    owner_e              last_owner_q, last_owner_d;
    logic                drop_i_q, drop_i_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_ready_q, d_ready_d;

    logic   i_elig;
    logic   d_elig;
    logic   grant_valid;
    owner_e grant_owner;

    // A port whose ready is high is still holding its just-completed request.
    assign i_elig = i_req & ~i_ready_q & ~i_flush;
    assign d_elig = d_req & ~d_ready_q;

    mem_arb_pick u_pick (
        .i_elig      (i_elig),
        .d_elig      (d_elig),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        drop_i_d     = drop_i_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        i_rdata_d    = i_rdata_q;
        i_ready_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_ready_d    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    mem_req_d = 1'b1;
                    if (grant_owner == OWNER_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                        state_d     = ARB_WAIT_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                        state_d     = ARB_WAIT_I;
                    end
                end
            end

            ARB_WAIT_I: begin
                if (mem_rvalid) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWNER_I;
                    drop_i_d     = 1'b0;
                    // A flush arriving with the response still discards it.
                    if (!(drop_i_q || i_flush)) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end
                end else if (i_flush) begin
                    drop_i_d = 1'b1;
                end
            end

            ARB_WAIT_D: begin
                if (mem_rvalid) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWNER_D;
                    d_ready_d    = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWNER_D;
            drop_i_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            i_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            drop_i_q     <= drop_i_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            i_rdata_q    <= i_rdata_d;
            i_ready_q    <= i_ready_d;
            d_rdata_q    <= d_rdata_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign arb_busy  = (state_q != ARB_IDLE);

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(i_ready_q && d_ready_q));
    a_req_single: assert property (@(posedge clk) disable iff (reset)
        mem_req_q |=> !mem_req_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        arb_busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int inv_viol = 0;

    // Backing memory: sees mem_req on the falling edge, answers lat_cfg falling edges later.
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    int          lat_cfg = 2;
    bit          rand_lat = 1'b0;
    int          stray_req = 0;
    int          stray_done = 0;
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        logic [31:0] w;
        mem_rvalid = 1'b0;
        if (reset) begin
            m_pend     = 1'b0;
            stray_done = stray_req;
        end else begin
            if (m_pend) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_store.exists(m_addr) ? mem_store[m_addr] : init_word(m_addr);
                    m_pend     = 1'b0;
                end
            end else if (stray_done != stray_req) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
                stray_done = stray_req;
            end
            if (mem_req) begin
                m_pend = 1'b1;
                m_addr = mem_addr;
                m_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
                if (mem_we) begin
                    w = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_store[mem_addr] = w;
                end
            end
        end
    end

    // Event log filled by observe(); cycle numbers count falling edges from 1.
    int          q_mreq_cyc[$];
    logic [31:0] q_maddr[$];
    logic [31:0] q_mwdata[$];
    logic        q_mwe[$];
    logic [3:0]  q_mwstrb[$];
    int          q_i_cyc[$];
    int          q_d_cyc[$];
    logic [31:0] q_i_data[$];
    logic [31:0] q_d_data[$];
    bit          hold_req = 1'b0;

    task automatic observe(input int n);
        bit prev_mreq = 1'b0;
        q_mreq_cyc.delete(); q_maddr.delete(); q_mwdata.delete(); q_mwe.delete(); q_mwstrb.delete();
        q_i_cyc.delete(); q_d_cyc.delete(); q_i_data.delete(); q_d_data.delete();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (prev_mreq) inv_viol++;
                q_mreq_cyc.push_back(c); q_maddr.push_back(mem_addr); q_mwdata.push_back(mem_wdata);
                q_mwe.push_back(mem_we); q_mwstrb.push_back(mem_wstrb);
            end
            prev_mreq = mem_req;
            if (i_ready && d_ready) inv_viol++;
            if (i_ready) begin
                q_i_cyc.push_back(c); q_i_data.push_back(i_rdata);
                if (!hold_req) i_req = 1'b0;
            end
            if (d_ready) begin
                q_d_cyc.push_back(c); q_d_data.push_back(d_rdata);
                if (!hold_req) d_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if ({i_ready, d_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {i_ready, d_ready}); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
        total++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin bad++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata, mem_wstrb}); end
        total++; if ({i_rdata, d_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        mem_store[32'h100] = 32'hDEADBEEF;
        lat_cfg = 2;
        i_addr = 32'h100; i_req = 1'b1;
        observe(12);
        total++;
        if (q_mreq_cyc.size() != 1) begin bad++; $display("FAIL fetch_mreq_count: got %0d want 1", q_mreq_cyc.size()); end
        else begin
            total++; if (q_maddr[0] !== 32'h100) begin bad++; $display("FAIL fetch_addr: got %h want 00000100", q_maddr[0]); end
            total++; if ({q_mwe[0], q_mwstrb[0]} !== 5'b0) begin bad++; $display("FAIL fetch_we_strb: got %b want 00000", {q_mwe[0], q_mwstrb[0]}); end
            total++; if (q_mreq_cyc[0] != 1) begin bad++; $display("FAIL fetch_issue_cycle: got %0d want 1", q_mreq_cyc[0]); end
        end
        total++;
        if (q_i_cyc.size() != 1) begin bad++; $display("FAIL fetch_iready_count: got %0d want 1", q_i_cyc.size()); end
        else begin
            total++; if (q_i_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", q_i_data[0]); end
            if (q_mreq_cyc.size() == 1) begin
                total++; if (q_i_cyc[0] - q_mreq_cyc[0] != 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", q_i_cyc[0] - q_mreq_cyc[0]); end
            end
        end
        total++; if (q_d_cyc.size() != 0) begin bad++; $display("FAIL fetch_dready: got %0d pulses want 0", q_d_cyc.size()); end
    endtask

    task automatic test_simultaneous();
        // The fetch test left last_owner = I, so D wins first under either arbitration mode.
        mem_store[32'h2000] = 32'h0BADF00D;
        lat_cfg = 2;
        i_addr = 32'h100;  i_req = 1'b1;
        d_addr = 32'h2000; d_we = 1'b0; d_req = 1'b1;
        observe(20);
        total++;
        if (q_mreq_cyc.size() != 2) begin bad++; $display("FAIL simul_mreq_count: got %0d want 2", q_mreq_cyc.size()); end
        else begin
            total++; if (q_maddr[0] !== 32'h2000) begin bad++; $display("FAIL simul_first_addr: got %h want 00002000", q_maddr[0]); end
            total++; if (q_maddr[1] !== 32'h100) begin bad++; $display("FAIL simul_second_addr: got %h want 00000100", q_maddr[1]); end
            if (q_d_cyc.size() == 1) begin
                total++;
                if (q_mreq_cyc[1] != q_d_cyc[0] + 1) begin
                    bad++; $display("FAIL simul_i_grant_at_d_ready_edge: mem_req cycle %0d want %0d", q_mreq_cyc[1], q_d_cyc[0] + 1);
                end
            end
        end
        total++; if (q_d_cyc.size() != 1) begin bad++; $display("FAIL simul_dready_count: got %0d want 1", q_d_cyc.size()); end
        else begin
            total++; if (q_d_data[0] !== 32'h0BADF00D) begin bad++; $display("FAIL simul_drdata: got %h want 0badf00d", q_d_data[0]); end
        end
        total++; if (q_i_cyc.size() != 1) begin bad++; $display("FAIL simul_iready_count: got %0d want 1", q_i_cyc.size()); end
        else begin
            total++; if (q_i_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL simul_irdata: got %h want deadbeef", q_i_data[0]); end
        end
    endtask

    task automatic test_store();
        lat_cfg = 1;
        i_flush = 1'b1;  // flush must not disturb a D transaction
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wstrb = 4'b0011; d_req = 1'b1;
        observe(10);
        i_flush = 1'b0; d_we = 1'b0;
        total++;
        if (q_mreq_cyc.size() != 1) begin bad++; $display("FAIL store_mreq_count: got %0d want 1", q_mreq_cyc.size()); end
        else begin
            total++;
            if ({q_mwe[0], q_mwstrb[0], q_maddr[0], q_mwdata[0]} !== {1'b1, 4'b0011, 32'h40, 32'h12345678}) begin
                bad++; $display("FAIL store_bus: got we=%b strb=%b addr=%h data=%h want we=1 strb=0011 addr=00000040 data=12345678",
                                q_mwe[0], q_mwstrb[0], q_maddr[0], q_mwdata[0]);
            end
        end
        total++; if (q_d_cyc.size() != 1) begin bad++; $display("FAIL store_dready_count: got %0d want 1", q_d_cyc.size()); end
        else if (q_mreq_cyc.size() == 1) begin
            total++; if (q_d_cyc[0] - q_mreq_cyc[0] != 2) begin bad++; $display("FAIL store_latency: got %0d want 2", q_d_cyc[0] - q_mreq_cyc[0]); end
        end
        total++; if (d_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL store_rdata_held: got %h want 0badf00d", d_rdata); end
    endtask

    task automatic test_flush();
        lat_cfg = 3;
        i_addr = 32'h300; i_req = 1'b1;
        @(negedge clk);
        total++; if ({mem_req, arb_busy} !== 2'b11) begin bad++; $display("FAIL flush_issue: got req/busy %b want 11", {mem_req, arb_busy}); end
        i_flush = 1'b1; i_req = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        observe(8);
        total++; if (q_i_cyc.size() != 0) begin bad++; $display("FAIL flush_dropped_iready: got %0d pulses want 0", q_i_cyc.size()); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL flush_back_idle: busy %b want 0", arb_busy); end
        total++; if (i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL flush_rdata_held: got %h want deadbeef", i_rdata); end
        // Flush in idle only blocks the grant for that one cycle.
        mem_store[32'h200] = 32'hCAFEF00D;
        lat_cfg = 2;
        i_addr = 32'h200; i_req = 1'b1; i_flush = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_idle_block: mem_req %b want 0", mem_req); end
        i_flush = 1'b0;
        observe(10);
        total++;
        if (q_mreq_cyc.size() != 1 || q_mreq_cyc[0] != 1) begin
            bad++; $display("FAIL flush_refetch_issue: %0d issues want one at cycle 1", q_mreq_cyc.size());
        end
        total++; if (q_i_cyc.size() != 1) begin bad++; $display("FAIL flush_refetch_iready: got %0d want 1", q_i_cyc.size()); end
        else begin
            total++; if (q_i_data[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL flush_refetch_data: got %h want cafef00d", q_i_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        lat_cfg = 3;
        d_addr = 32'h2000; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got %b want 1", arb_busy); end
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, i_ready, d_ready, arb_busy, mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: req=%b busy=%b addr=%h drdata=%h want all 0", mem_req, arb_busy, mem_addr, d_rdata);
        end
        reset = 1'b0;
        stray_req++;
        observe(6);
        total++; if (q_i_cyc.size() + q_d_cyc.size() != 0) begin bad++; $display("FAIL rstmid_stray_ready: got %0d pulses want 0", q_i_cyc.size() + q_d_cyc.size()); end
        total++; if (q_mreq_cyc.size() != 0) begin bad++; $display("FAIL rstmid_stray_issue: got %0d want 0", q_mreq_cyc.size()); end
    endtask

    task automatic test_rr();
        logic [31:0] want;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat_cfg = 1; hold_req = 1'b1;
        i_addr = 32'h100; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        observe(30);
        hold_req = 1'b0; i_req = 1'b0; d_req = 1'b0;
        total++;
        if (q_maddr.size() < 4) begin bad++; $display("FAIL rr_grant_count: got %0d want >=4", q_maddr.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
                want = (k % 2 == 0) ? 32'h100 : 32'h2000;
`else
                want = (k % 2 == 0) ? 32'h2000 : 32'h100;
`endif
                total++;
                if (q_maddr[k] !== want) begin bad++; $display("FAIL rr_grant_order[%0d]: got %h want %h", k, q_maddr[k], want); end
            end
        end
        observe(6);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic test_random();
        bit ip = 1'b0, dp = 1'b0, prev = 1'b0, ok;
        int iage = 0, dage = 0;
        logic [31:0] ia = '0, da = '0, dwd = '0, w;
        logic dwe = 1'b0;
        logic [3:0] dws = '0;
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (mem_req) begin
                total++;
                ok = (ip && !mem_we && mem_addr == ia && mem_wstrb == 4'b0) ||
                     (dp && mem_we == dwe && mem_addr == da && (!dwe || (mem_wdata == dwd && mem_wstrb == dws)));
                if (prev || !ok) begin bad++; $display("FAIL rand_issue: addr=%h we=%b back_to_back=%b", mem_addr, mem_we, prev); end
            end
            prev = mem_req;
            total++;
            if (i_ready && d_ready) begin bad++; $display("FAIL rand_both_ready: got 11 want at most one"); end
            if (i_ready) begin
                total++;
                if (!ip) begin bad++; $display("FAIL rand_spurious_iready: addr=%h", ia); end
                else if (i_rdata !== model_read(ia)) begin bad++; $display("FAIL rand_irdata: addr=%h got %h want %h", ia, i_rdata, model_read(ia)); end
                ip = 1'b0; i_req = 1'b0;
            end
            if (d_ready) begin
                total++;
                if (!dp) begin bad++; $display("FAIL rand_spurious_dready: addr=%h", da); end
                else if (dwe) begin
                    w = model_read(da);
                    for (int b = 0; b < 4; b++) if (dws[b]) w[8*b +: 8] = dwd[8*b +: 8];
                    shadow[da] = w;
                end else if (d_rdata !== model_read(da)) begin
                    bad++; $display("FAIL rand_drdata: addr=%h got %h want %h", da, d_rdata, model_read(da));
                end
                dp = 1'b0; d_req = 1'b0;
            end
            if (ip) begin
                iage++;
                if (iage > 80) begin total++; bad++; $display("FAIL rand_i_timeout: addr=%h", ia); ip = 1'b0; i_req = 1'b0; end
            end
            if (dp) begin
                dage++;
                if (dage > 80) begin total++; bad++; $display("FAIL rand_d_timeout: addr=%h", da); dp = 1'b0; d_req = 1'b0; end
            end
            i_flush = 1'b0;
            if (ip && $urandom_range(0, 29) == 0) begin
                i_flush = 1'b1; i_req = 1'b0; ip = 1'b0;
            end else if (!ip && $urandom_range(0, 2) == 0) begin
                ia = 32'h1000 + 32'(4 * $urandom_range(0, 15));
                i_addr = ia; i_req = 1'b1; ip = 1'b1; iage = 0;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                da = 32'h1000 + 32'(4 * $urandom_range(0, 15));
                dwe = 1'($urandom_range(0, 1)); dwd = $urandom; dws = 4'($urandom_range(0, 15));
                d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws; d_req = 1'b1; dp = 1'b1; dage = 0;
            end
        end
        i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rand_drain_idle: busy %b want 0", arb_busy); end
        rand_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_flush();
        test_reset_mid();
        test_rr();
        test_random();
        total++;
        if (inv_viol != 0) begin bad++; $display("FAIL invariants: %0d violations want 0", inv_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
